seg_scan_driver: RTL

- Downstream display stage of the fan controller. Consumes battery level (0-99), fan gear (0-3) and charging flag; drives the 8-digit multiplexed seven-segment display.
- Conversion: sequential binary-to-BCD, once per scan frame.
- Display features: digit scanning, low-battery blink, charging indicator on the decimal point.

---
 rtl/seg_scan_driver.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit seven-segment driver: battery level (BCD), gear and charge dot.
// Optional macro LEADING_ZERO_BLANK_EN suppresses a zero tens digit.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 250000,
    parameter int LOW_BATT  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] battery,
    input  logic [1:0] gear,
    input  logic       charging,
    output logic [7:0] seg,
    output logic [7:0] dig_sel
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_MAX   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX  = BLINK_W'(BLINK_DIV - 1);
    localparam logic [6:0]         LOW_BATT_V = 7'(LOW_BATT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] enc;
        case (digit)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h00;
        endcase
        return enc;
    endfunction

    function automatic logic [6:0] clamp_battery(input logic [6:0] raw);
        return (raw > 7'd99) ? 7'd99 : raw;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]         digit_idx_q, digit_idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [6:0]         snap_battery_q, snap_battery_d;
    logic [1:0]         snap_gear_q, snap_gear_d;
    logic               snap_charging_q, snap_charging_d;
    logic [1:0]         state_q, state_d;
    logic [6:0]         rem_q, rem_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         disp_tens_q, disp_tens_d;
    logic [3:0]         disp_ones_q, disp_ones_d;
    logic [7:0]         seg_q, seg_d;
    logic [7:0]         dig_sel_q, dig_sel_d;
    logic               scan_tc_s, frame_s, blink_tc_s, blank_s;

    // Scan and blink timebases plus frame-boundary snapshot.
    always_comb begin
        scan_tc_s   = (scan_cnt_q == SCAN_MAX);
        frame_s     = scan_tc_s && (digit_idx_q == 3'd7);
        blink_tc_s  = (blink_cnt_q == BLINK_MAX);
        scan_cnt_d  = scan_tc_s ? '0 : scan_cnt_q + SCAN_W'(1);
        digit_idx_d = scan_tc_s ? digit_idx_q + 3'd1 : digit_idx_q;
        blink_cnt_d = blink_tc_s ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_tc_s ? ~blink_phase_q : blink_phase_q;
        if (frame_s) begin
            snap_battery_d  = clamp_battery(battery);
            snap_gear_d     = gear;
            snap_charging_d = charging;
        end else begin
            snap_battery_d  = snap_battery_q;
            snap_gear_d     = snap_gear_q;
            snap_charging_d = snap_charging_q;
        end
    end

    // Repeated-subtraction BCD conversion; a frame boundary always restarts it.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        tens_d      = tens_q;
        disp_tens_d = disp_tens_q;
        disp_ones_d = disp_ones_q;
        if (frame_s) begin
            state_d = ST_CONV;
            rem_d   = clamp_battery(battery);
            tens_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_CONV: begin
                    if (rem_q >= 7'd10) begin
                        rem_d  = rem_q - 7'd10;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    disp_tens_d = tens_q;
                    disp_ones_d = rem_q[3:0];
                    state_d     = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Segment pattern for the digit currently selected; registered with dig_sel.
    always_comb begin
        blank_s   = (snap_battery_q < LOW_BATT_V) && !snap_charging_q && !blink_phase_q;
        dig_sel_d = ~(8'b0000_0001 << digit_idx_q);
        case (digit_idx_q)
            3'd0: begin
                if (blank_s) begin
                    seg_d = 8'h00;
                end else begin
                    seg_d = {snap_charging_q, seg_encode(disp_ones_q)};
                end
            end
            3'd1: begin
                if (blank_s) begin
                    seg_d = 8'h00;
                end else begin
`ifdef LEADING_ZERO_BLANK_EN
                    seg_d = (disp_tens_q == 4'd0) ? 8'h00 : {1'b0, seg_encode(disp_tens_q)};
`else
                    seg_d = {1'b0, seg_encode(disp_tens_q)};
`endif
                end
            end
            3'd3:    seg_d = {1'b0, seg_encode({2'b00, snap_gear_q})};
            default: seg_d = 8'h00;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q      <= '0;
            digit_idx_q     <= 3'd0;
            blink_cnt_q     <= '0;
            blink_phase_q   <= 1'b1;
            snap_battery_q  <= 7'd0;
            snap_gear_q     <= 2'd0;
            snap_charging_q <= 1'b0;
            state_q         <= ST_IDLE;
            rem_q           <= 7'd0;
            tens_q          <= 4'd0;
            disp_tens_q     <= 4'd0;
            disp_ones_q     <= 4'd0;
            seg_q           <= 8'h00;
            dig_sel_q       <= 8'hFF;
        end else begin
            scan_cnt_q      <= scan_cnt_d;
            digit_idx_q     <= digit_idx_d;
            blink_cnt_q     <= blink_cnt_d;
            blink_phase_q   <= blink_phase_d;
            snap_battery_q  <= snap_battery_d;
            snap_gear_q     <= snap_gear_d;
            snap_charging_q <= snap_charging_d;
            state_q         <= state_d;
            rem_q           <= rem_d;
            tens_q          <= tens_d;
            disp_tens_q     <= disp_tens_d;
            disp_ones_q     <= disp_ones_d;
            seg_q           <= seg_d;
            dig_sel_q       <= dig_sel_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule
